// File: rtl/stopwatch_lap_core_pkg.sv
// Shared types and constants for the BCD stopwatch/timer core.
package stopwatch_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } sw_state_e;

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Control pulses in and display/flag bus out between the switch front end and the stopwatch core.
interface stopwatch_lap_core_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    start_stop_p;
  logic                    clear_p;
  logic                    lap_p;
  logic                    load_p;
  logic [4*NUM_DIGITS-1:0] load_bcd;
  logic                    mode_down;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    running;
  logic                    lap_active;
  logic                    ovf;
  logic                    expired;
  logic                    tick;

  modport master (
    output start_stop_p, clear_p, lap_p, load_p, load_bcd, mode_down,
    input  disp_bcd, running, lap_active, ovf, expired, tick
  );

  modport slave (
    input  start_stop_p, clear_p, lap_p, load_p, load_bcd, mode_down,
    output disp_bcd, running, lap_active, ovf, expired, tick
  );
endinterface

// File: rtl/stopwatch_lap_core_bcd_digit.sv
// One BCD decade: synchronous clear/load, up/down step gated by the ripple carry/borrow chain.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] q,
  output logic             carry_out,
  output logic             borrow_out
);

  assign carry_out  = carry_in  && (q == BCD_MAX);
  assign borrow_out = borrow_in && (q == '0);

  always_ff @(posedge clk) begin
    if (!rstb || clr)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (inc && carry_in)
      q <= (q == BCD_MAX) ? '0 : q + 1'b1;
    else if (dec && borrow_in)
      q <= (q == '0) ? BCD_MAX : q - 1'b1;
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// BCD stopwatch/timer core: run/pause FSM, tick prescaler, lap snapshot, overflow and expiry flags.
//   state   | meaning
//   IDLE    | count zero after clear or reset
//   RUN     | prescaler advancing, count steps on every tick
//   PAUSE   | count and prescaler held (after stop or load)
//   EXPIRED | countdown reached zero, waits for clear or load
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 500000
) (
  input logic                 clk,
  input logic                 rstb,
  stopwatch_lap_core_if.slave sw
);

  localparam int CW = BCD_W * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);

  sw_state_e       state, state_nxt;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   count, lap_reg;
  logic            mode_dn, lap_active, ovf, expired;
  logic            tick, step, expire;
  logic            do_clear, do_load, do_start, do_stop, lap_sel, do_lap_set, do_lap_clr;
  logic            count_zero, count_one;
  logic [NUM_DIGITS:0] carry, borrow;

  assign tick       = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign count_zero = (count == '0);
  assign count_one  = (count == CW'(1));

  // Lower-priority pulses are masked whenever a higher-priority pulse is present.
  assign do_clear   = sw.clear_p;
  assign do_load    = !sw.clear_p && sw.load_p && (state != RUN);
  assign do_start   = !sw.clear_p && !sw.load_p && sw.start_stop_p &&
                      ((state == IDLE) || (state == PAUSE)) && !(sw.mode_down && count_zero);
  assign do_stop    = !sw.clear_p && !sw.load_p && sw.start_stop_p && (state == RUN);
  assign lap_sel    = !sw.clear_p && !sw.load_p && !sw.start_stop_p && sw.lap_p;
  assign do_lap_set = lap_sel && !lap_active && (state == RUN);
  assign do_lap_clr = lap_sel && lap_active;

  assign step   = tick && !do_clear;
  assign expire = step && mode_dn && (count_one || borrow[NUM_DIGITS]);

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rstb       (rstb),
      .clr        (do_clear),
      .load       (do_load),
      .load_val   (sw.load_bcd[i*BCD_W +: BCD_W]),
      .inc        (step && !mode_dn),
      .dec        (step && mode_dn),
      .carry_in   (carry[i]),
      .borrow_in  (borrow[i]),
      .q          (count[i*BCD_W +: BCD_W]),
      .carry_out  (carry[i+1]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Expiry outranks a coincident stop so a zero countdown always lands in EXPIRED.
  always_comb begin
    state_nxt = state;
    if (do_clear)      state_nxt = IDLE;
    else if (do_load)  state_nxt = PAUSE;
    else if (expire)   state_nxt = EXPIRED;
    else if (do_stop)  state_nxt = PAUSE;
    else if (do_start) state_nxt = RUN;
  end

  always_comb begin
    sw.disp_bcd   = lap_active ? lap_reg : count;
    sw.running    = (state == RUN);
    sw.lap_active = lap_active;
    sw.ovf        = ovf;
    sw.expired    = expired;
    sw.tick       = tick;
  end

  always_ff @(posedge clk) begin
    if (!rstb || do_clear)  presc <= '0;
    else if (state == RUN)  presc <= tick ? '0 : presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      mode_dn    <= 1'b0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
      expired    <= 1'b0;
    end else if (do_clear) begin
      lap_active <= 1'b0;
      ovf        <= 1'b0;
      expired    <= 1'b0;
    end else begin
      if (do_start) mode_dn <= sw.mode_down;
      if (do_lap_set) begin
        lap_reg    <= count;
        lap_active <= 1'b1;
      end else if (do_lap_clr) begin
        lap_active <= 1'b0;
      end
      if (step && !mode_dn && carry[NUM_DIGITS]) ovf <= 1'b1;
      if (do_load)     expired <= 1'b0;
      else if (expire) expired <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core: cycle model feeds an expected-output queue, plus scenario spot checks.
module tb_stopwatch_lap_core;

  localparam int TD   = 4;
  localparam int ND   = 4;
  localparam int MAXC = 10000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic clk = 1'b0;
  logic rstb = 1'b0;

  stopwatch_lap_core_if #(.NUM_DIGITS(ND)) sw_if();

  stopwatch_lap_core #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk  (clk),
    .rstb (rstb),
    .sw   (sw_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  // Reference model: decimal count, independent of the RTL structure.
  int m_state, m_cnt, m_lap, m_presc;
  bit m_lapact, m_ovf, m_exp, m_mdn;
  logic [20:0] exp_q[$];

  always @(posedge clk) begin : model
    bit t;
    int ns;
    t = (m_state == S_RUN) && (m_presc == TD - 1);
    if (!rstb) begin
      m_state = S_IDLE; m_cnt = 0; m_lap = 0; m_presc = 0;
      m_lapact = 0; m_ovf = 0; m_exp = 0; m_mdn = 0;
    end else if (sw_if.clear_p) begin
      m_state = S_IDLE; m_cnt = 0; m_presc = 0;
      m_lapact = 0; m_ovf = 0; m_exp = 0;
    end else begin
      ns = m_state;
      if (m_state == S_RUN) m_presc = t ? 0 : m_presc + 1;
      if (sw_if.load_p) begin
        if (m_state != S_RUN) begin
          m_cnt = from_bcd(sw_if.load_bcd);
          ns = S_PAUSE;
          m_exp = 0;
        end
      end else if (sw_if.start_stop_p) begin
        if (m_state == S_RUN) ns = S_PAUSE;
        else if ((m_state == S_IDLE || m_state == S_PAUSE) && !(sw_if.mode_down && m_cnt == 0)) begin
          ns = S_RUN;
          m_mdn = sw_if.mode_down;
        end
      end else if (sw_if.lap_p) begin
        if (m_lapact) m_lapact = 0;
        else if (m_state == S_RUN) begin
          m_lapact = 1;
          m_lap = m_cnt;
        end
      end
      if (t) begin
        if (!m_mdn) begin
          m_cnt++;
          if (m_cnt == MAXC) begin m_cnt = 0; m_ovf = 1; end
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin ns = S_EXP; m_exp = 1; end
        end
      end
      m_state = ns;
    end
    exp_q.push_back({to_bcd(m_lapact ? m_lap : m_cnt), m_state == S_RUN, m_lapact,
                     m_ovf, m_exp, (m_state == S_RUN) && (m_presc == TD - 1)});
  end

  always @(negedge clk) begin : scoreboard
    logic [20:0] e;
    if (sw_if.tick) tick_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'({sw_if.disp_bcd, sw_if.running, sw_if.lap_active,
                            sw_if.ovf, sw_if.expired, sw_if.tick}), 32'(e));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input string which);
    case (which)
      "start": sw_if.start_stop_p = 1'b1;
      "clear": sw_if.clear_p      = 1'b1;
      "lap":   sw_if.lap_p        = 1'b1;
      default: sw_if.load_p       = 1'b1;
    endcase
    cyc(1);
    sw_if.start_stop_p = 1'b0;
    sw_if.clear_p      = 1'b0;
    sw_if.lap_p        = 1'b0;
    sw_if.load_p       = 1'b0;
  endtask

  task automatic load_value(input logic [15:0] v);
    sw_if.load_bcd = v;
    pulse("load");
  endtask

  int t0;
  bit found;

  initial begin
    sw_if.start_stop_p = 1'b0;
    sw_if.clear_p      = 1'b0;
    sw_if.lap_p        = 1'b0;
    sw_if.load_p       = 1'b0;
    sw_if.load_bcd     = '0;
    sw_if.mode_down    = 1'b0;
    cyc(2);
    check("rst_disp", 32'(sw_if.disp_bcd), 32'h0);
    check("rst_running", 32'(sw_if.running), 32'd0);
    rstb = 1'b1;
    cyc(1);

    // Count up 12 ticks, then pause and hold.
    pulse("start");
    t0 = tick_cnt;
    cyc(48);
    check("run48_disp", 32'(sw_if.disp_bcd), 32'h0012);
    check("run48_running", 32'(sw_if.running), 32'd1);
    check("run48_ticks", 32'(tick_cnt - t0), 32'd12);
    pulse("start");
    cyc(10);
    check("pause_hold", 32'(sw_if.disp_bcd), 32'h0012);
    check("pause_running", 32'(sw_if.running), 32'd0);

    // Lap hold while counting continues.
    pulse("start");
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (sw_if.disp_bcd == 16'h0025) found = 1;
      else cyc(1);
    end
    check("reach_0025", 32'(found), 32'd1);
    pulse("lap");
    cyc(40);
    check("lap_frozen", 32'(sw_if.disp_bcd), 32'h0025);
    check("lap_active", 32'(sw_if.lap_active), 32'd1);
    pulse("lap");
    check("lap_release", 32'(sw_if.disp_bcd), 32'h0035);

    // Up-count overflow.
    pulse("clear");
    load_value(16'h9998);
    pulse("start");
    cyc(8);
    check("ovf_disp", 32'(sw_if.disp_bcd), 32'h0000);
    check("ovf_flag", 32'(sw_if.ovf), 32'd1);
    check("ovf_running", 32'(sw_if.running), 32'd1);
    pulse("clear");
    check("clr_ovf", 32'(sw_if.ovf), 32'd0);
    check("clr_running", 32'(sw_if.running), 32'd0);

    // Countdown expiry.
    sw_if.mode_down = 1'b1;
    load_value(16'h0003);
    pulse("start");
    cyc(12);
    check("exp_disp", 32'(sw_if.disp_bcd), 32'h0000);
    check("exp_flag", 32'(sw_if.expired), 32'd1);
    check("exp_running", 32'(sw_if.running), 32'd0);
    pulse("start");
    check("exp_start_ignored", 32'(sw_if.running), 32'd0);
    pulse("clear");
    check("exp_cleared", 32'(sw_if.expired), 32'd0);
    sw_if.mode_down = 1'b0;

    // clear_p beats start_stop_p in RUN.
    pulse("start");
    cyc(5);
    sw_if.clear_p = 1'b1;
    sw_if.start_stop_p = 1'b1;
    cyc(1);
    sw_if.clear_p = 1'b0;
    sw_if.start_stop_p = 1'b0;
    check("clr_start_running", 32'(sw_if.running), 32'd0);
    check("clr_start_disp", 32'(sw_if.disp_bcd), 32'h0);

    // Stop on a tick cycle still applies the increment.
    load_value(16'h0007);
    pulse("start");
    cyc(3);
    check("tick_cycle", 32'(sw_if.tick), 32'd1);
    pulse("start");
    check("stop_tick_disp", 32'(sw_if.disp_bcd), 32'h0008);
    check("stop_tick_running", 32'(sw_if.running), 32'd0);

    // Pause with prescaler at 2, resume: change at the 2nd edge.
    pulse("start");
    cyc(1);
    pulse("start");
    cyc(3);
    pulse("start");
    cyc(1);
    check("resume_edge1", 32'(sw_if.disp_bcd), 32'h0008);
    cyc(1);
    check("resume_edge2", 32'(sw_if.disp_bcd), 32'h0009);

    // Reset mid-RUN with lap active overrides a coincident start.
    pulse("lap");
    cyc(2);
    rstb = 1'b0;
    sw_if.start_stop_p = 1'b1;
    cyc(1);
    rstb = 1'b1;
    sw_if.start_stop_p = 1'b0;
    check("rst_run_outputs", 32'({sw_if.disp_bcd, sw_if.running, sw_if.lap_active,
                                  sw_if.ovf, sw_if.expired, sw_if.tick}), 32'h0);
    cyc(8);
    check("rst_run_idle", 32'(sw_if.running), 32'd0);
    check("rst_run_disp", 32'(sw_if.disp_bcd), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
